gumnut_operand_fetch: RTL and testbench
=======================================

// Module: gumnut_operand_fetch
// PURPOSE
// - Operand-fetch stage directly upstream of the Gumnut ALU: accepts an 18-bit instruction, decodes register fields,
//   reads the 8x8 GPR bank, presents registered IR/GPR_rs/GPR_r2 to the ALU/execute stage.
// - Owns the GPR bank and its writeback port; an 8-bit scoreboard stalls RAW/WAW hazards against results still in flight.
// PARAMETERS
// - DATA_W    8   GPR width
// - NUM_GPR   8   register count (r0..r7); index width 3
// PORTS
// - clk         in   1   rising-edge clock
// - rst_n       in   1   asynchronous active-low reset
// - ir_in       in   18  instruction from fetch
// - ir_valid    in   1   ir_in valid
// - ir_ready    out  1   stage accepts ir_in this cycle
// - IR          out  18  registered instruction to ALU
// - GPR_rs      out  8   registered rs operand
// - GPR_r2      out  8   registered r2 operand (store/out: data register from rd field)
// - op_valid    out  1   IR/GPR_rs/GPR_r2 valid
// - op_ready    in   1   downstream accepts operands
// - wb_en       in   1   writeback strobe
// - wb_rd       in   3   writeback destination
// - wb_data     in   8   writeback value
// - stall_cnt   out  16  saturating count of hazard-stall cycles
// BEHAVIOUR
// - Decode classes: ALU-reg IR[17:14]=1110 (rd[13:11] rs[10:8] r2[7:5]); ALU-imm IR[17]=0 (rd, rs); shift IR[17:15]=110
//   (rd, rs); mem IR[17:16]=10, fn IR[15:14]: ldm/inp (00/10) read rs, write rd; stm/out (01/11) read rs and rd (rd->GPR_r2).
//   Jump/branch/misc (IR[17:13]=11110 or above): no GPR read/write, GPR_rs=GPR_r2=0.
// - r0 reads 0 always; wb_en with wb_rd=0 ignored; r0 never marked pending.
// - Hazard = any used source or destination (rd!=0) has pending bit set.
// - ir_ready = (!op_valid || op_ready) && !hazard. Accept when ir_valid && ir_ready.
// - Latency: accept in cycle N -> op_valid, IR, GPR_rs, GPR_r2 registered at N+1. Full throughput 1/cycle without hazards.
// - Output held stable while op_valid && !op_ready; op_valid drops when op_ready && no new accept.
// - Scoreboard: on accept of writing instruction set pending[rd]; on wb_en clear pending[wb_rd]. Set and clear of the same
//   index same cycle cannot occur (WAW stalls); different indices both take effect.
// - wb_en writes GPR at clock edge; read in the same cycle returns old value (no bypass build) -> hazard persists that cycle.
// - stall_cnt increments each cycle ir_valid && hazard; saturates at 16'hFFFF.
// - Reset (any time, incl. mid-stall): op_valid=0, IR=0, GPR_rs=0, GPR_r2=0, all GPRs=0, pending=0, stall_cnt=0;
//   in-flight instruction dropped; wb_en after reset release writes normally, clears nothing spurious.
// CONFIGURATION
// - GUMNUT_WB_BYPASS_EN defined: wb_en && wb_rd==src (src!=0) forwards wb_data into the operand register and masks that
//   source's pending bit for the hazard check -> zero-bubble dependent issue.
// - Undefined: no forwarding; dependent instruction issues the cycle after writeback (one bubble).
// STRUCTURE
// - gumnut_pkg: IR field position localparams, class opcodes (ALU_REG, ALU_IMM, SHIFT, MEM), mem fn codes, DATA_W.
// - Sub-module gumnut_gpr_bank: 8x8 storage, 2 async read ports, 1 sync write port, r0 tied to 0, async active-low reset.
// - Top: decode, scoreboard, output register, optional bypass mux, stall counter.
// TESTING
// - Reset: after rst_n low, op_valid=0, IR=0, GPR_rs=GPR_r2=0, stall_cnt=0, ir_ready=1.
// - wb r1=7, r2=3; issue 18'b111_0001_001_010_00000 (add r1,r1,r2) -> next cycle op_valid=1, GPR_rs=7, GPR_r2=3.
// - Issue add r3<=r1+r2, then sub reading r3 -> ir_ready=0, stall_cnt=1+ until wb r3=10; no-bypass issues cycle after
//   wb with GPR_rs=10; GUMNUT_WB_BYPASS_EN issues in wb cycle with GPR_rs=10.
// - op_ready=0 for 3 cycles with op_valid=1 -> IR/GPR_rs/GPR_r2 unchanged, ir_ready=0; op_ready=1 -> next accepted.
// - stm with rd=r5=8'hA5, rs=r4=8'h10 -> GPR_rs=8'h10, GPR_r2=8'hA5; pending unchanged. wb to r0=8'hFF -> read r0=0.
// - rst_n low while r3 pending and op_valid=1 -> after release pending=0, op_valid=0, read r3 returns 0, no stall.

Source files
------------

// File: rtl/gumnut_pkg.sv
// Shared definitions for the Gumnut operand-fetch slice: instruction field
// positions, decode class opcodes, memory function codes and small helpers.
package gumnut_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_GPR = 8;
  localparam int IDX_W   = 3;
  localparam int IR_W    = 18;

  // Instruction field positions
  localparam int OPC_LSB = 14;  // IR[17:14] selects the decode class
  localparam int OPC_W   = 4;
  localparam int MFN_LSB = 14;  // IR[15:14] memory function
  localparam int RD_LSB  = 11;  // IR[13:11]
  localparam int RS_LSB  = 8;   // IR[10:8]
  localparam int R2_LSB  = 5;   // IR[7:5]

  // Class opcodes, matched against the leading bits of IR
  localparam logic [0:0] OPC_ALU_IMM = 1'b0;
  localparam logic [1:0] OPC_MEM     = 2'b10;
  localparam logic [2:0] OPC_SHIFT   = 3'b110;
  localparam logic [3:0] OPC_ALU_REG = 4'b1110;

  // Memory function codes
  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_STM = 2'b01;
  localparam logic [1:0] MEM_INP = 2'b10;
  localparam logic [1:0] MEM_OUT = 2'b11;

  typedef enum logic [2:0] {
    CLS_ALU_REG = 3'd0,
    CLS_ALU_IMM = 3'd1,
    CLS_SHIFT   = 3'd2,
    CLS_MEM     = 3'd3,
    CLS_OTHER   = 3'd4
  } op_class_e;

  // Classify an instruction from IR[17:14]; everything at 1111 and above is
  // jump/branch/misc and touches no GPR.
  function automatic op_class_e decode_class(input logic [OPC_W-1:0] opc);
    op_class_e cls;
    if (opc[3] == OPC_ALU_IMM) begin
      cls = CLS_ALU_IMM;
    end else if (opc[3:2] == OPC_MEM) begin
      cls = CLS_MEM;
    end else if (opc[3:1] == OPC_SHIFT) begin
      cls = CLS_SHIFT;
    end else if (opc == OPC_ALU_REG) begin
      cls = CLS_ALU_REG;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

  // One-hot mask for a register index.
  function automatic logic [NUM_GPR-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_GPR-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/gumnut_gpr_bank.sv
// Gumnut 8x8 general-purpose register bank: two asynchronous read ports and
// one synchronous write port. r0 always reads zero and ignores writes.
module gumnut_gpr_bank
  import gumnut_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ra_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  ra_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_r [NUM_GPR];

  // Register storage: cleared on reset, written at the clock edge (r0 never written)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (wa != 3'd0)) begin
      regs_r[wa] <= wdata;
    end
  end

  // Read ports: r0 is hard-wired to zero
  always_comb begin
    rdata_a = {DATA_W{1'b0}};
    rdata_b = {DATA_W{1'b0}};
    if (ra_a != 3'd0) begin
      rdata_a = regs_r[ra_a];
    end else begin
      rdata_a = {DATA_W{1'b0}};
    end
    if (ra_b != 3'd0) begin
      rdata_b = regs_r[ra_b];
    end else begin
      rdata_b = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/gumnut_operand_fetch.sv
// Gumnut operand-fetch stage: decodes the incoming instruction, reads the GPR
// bank, stalls on scoreboard hazards and registers IR plus operands for the ALU.
// Optional feature: define GUMNUT_WB_BYPASS_EN to forward same-cycle writeback
// data into the operand registers (zero-bubble dependent issue).
module gumnut_operand_fetch
  import gumnut_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              ir_valid,
  output logic              ir_ready,
  output logic [IR_W-1:0]   IR,
  output logic [DATA_W-1:0] GPR_rs,
  output logic [DATA_W-1:0] GPR_r2,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [15:0]       stall_cnt
);

  op_class_e          cls_s;
  logic [IDX_W-1:0]   rd_idx_s, rs_idx_s, r2_idx_s;
  logic               use_rs_s, use_r2_s, writes_s;
  logic [DATA_W-1:0]  rs_data_s, r2_data_s, rs_opnd_s, r2_opnd_s;
  logic               fwd_rs_s, fwd_r2_s;
  logic [NUM_GPR-1:0] src_mask_s, fwd_mask_s, set_s, clr_s, pending_r;
  logic               hazard_s, accept_s;

  gumnut_gpr_bank u_gpr_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_a    (rs_idx_s),
    .rdata_a (rs_data_s),
    .ra_b    (r2_idx_s),
    .rdata_b (r2_data_s),
    .we      (wb_en),
    .wa      (wb_rd),
    .wdata   (wb_data)
  );

  // Decode: which register fields are read and whether rd is written
  always_comb begin
    cls_s    = decode_class(ir_in[OPC_LSB +: OPC_W]);
    rd_idx_s = ir_in[RD_LSB +: IDX_W];
    rs_idx_s = ir_in[RS_LSB +: IDX_W];
    r2_idx_s = ir_in[R2_LSB +: IDX_W];
    use_rs_s = 1'b0;
    use_r2_s = 1'b0;
    writes_s = 1'b0;
    case (cls_s)
      CLS_ALU_REG: begin
        use_rs_s = 1'b1;
        use_r2_s = 1'b1;
        writes_s = 1'b1;
      end
      CLS_ALU_IMM, CLS_SHIFT: begin
        use_rs_s = 1'b1;
        writes_s = 1'b1;
      end
      CLS_MEM: begin
        use_rs_s = 1'b1;
        if ((ir_in[MFN_LSB +: 2] == MEM_STM) || (ir_in[MFN_LSB +: 2] == MEM_OUT)) begin
          // store/out: rd field is the data source, routed through the second port
          use_r2_s = 1'b1;
          r2_idx_s = rd_idx_s;
        end else begin
          writes_s = 1'b1;
        end
      end
      default: begin
        use_rs_s = 1'b0;
        use_r2_s = 1'b0;
        writes_s = 1'b0;
      end
    endcase
  end

`ifdef GUMNUT_WB_BYPASS_EN
  assign fwd_rs_s = wb_en && use_rs_s && (wb_rd == rs_idx_s) && (rs_idx_s != 3'd0);
  assign fwd_r2_s = wb_en && use_r2_s && (wb_rd == r2_idx_s) && (r2_idx_s != 3'd0);
`else
  assign fwd_rs_s = 1'b0;
  assign fwd_r2_s = 1'b0;
`endif

  // Operand selection: unused operands are zero, forwarded ones take wb_data
  always_comb begin
    rs_opnd_s = {DATA_W{1'b0}};
    r2_opnd_s = {DATA_W{1'b0}};
    if (!use_rs_s) begin
      rs_opnd_s = {DATA_W{1'b0}};
    end else if (fwd_rs_s) begin
      rs_opnd_s = wb_data;
    end else begin
      rs_opnd_s = rs_data_s;
    end
    if (!use_r2_s) begin
      r2_opnd_s = {DATA_W{1'b0}};
    end else if (fwd_r2_s) begin
      r2_opnd_s = wb_data;
    end else begin
      r2_opnd_s = r2_data_s;
    end
  end

  // Hazard detection and scoreboard set/clear vectors
  always_comb begin
    src_mask_s = {NUM_GPR{1'b0}};
    fwd_mask_s = {NUM_GPR{1'b0}};
    set_s      = {NUM_GPR{1'b0}};
    clr_s      = {NUM_GPR{1'b0}};
    if (use_rs_s) src_mask_s = src_mask_s | idx_onehot(rs_idx_s);
    else          src_mask_s = src_mask_s;
    if (use_r2_s) src_mask_s = src_mask_s | idx_onehot(r2_idx_s);
    else          src_mask_s = src_mask_s;
    if (fwd_rs_s) fwd_mask_s = fwd_mask_s | idx_onehot(rs_idx_s);
    else          fwd_mask_s = fwd_mask_s;
    if (fwd_r2_s) fwd_mask_s = fwd_mask_s | idx_onehot(r2_idx_s);
    else          fwd_mask_s = fwd_mask_s;
    // Forwarding only relieves sources; a pending destination still stalls (WAW)
    hazard_s = (|(src_mask_s & pending_r & ~fwd_mask_s)) ||
               (writes_s && (rd_idx_s != 3'd0) && pending_r[rd_idx_s]);
    ir_ready = (!op_valid || op_ready) && !hazard_s;
    accept_s = ir_valid && ir_ready;
    if (accept_s && writes_s && (rd_idx_s != 3'd0)) set_s = idx_onehot(rd_idx_s);
    else                                            set_s = {NUM_GPR{1'b0}};
    if (wb_en && (wb_rd != 3'd0)) clr_s = idx_onehot(wb_rd);
    else                          clr_s = {NUM_GPR{1'b0}};
  end

  // Scoreboard: mark destinations in flight, release them on writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NUM_GPR{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
    end
  end

  // Output register: load on accept, hold under backpressure, drop when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      IR       <= {IR_W{1'b0}};
      GPR_rs   <= {DATA_W{1'b0}};
      GPR_r2   <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_valid <= 1'b1;
      IR       <= ir_in;
      GPR_rs   <= rs_opnd_s;
      GPR_r2   <= r2_opnd_s;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

  // Saturating count of cycles a valid instruction is held off by a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (ir_valid && hazard_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_gumnut_operand_fetch.sv
// Self-checking bench for gumnut_operand_fetch: directed scenarios followed by
// randomized instructions/writebacks checked against a register/scoreboard model.
module tb_gumnut_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] ir_in;
  logic        ir_valid;
  logic        ir_ready;
  logic [17:0] IR;
  logic [7:0]  GPR_rs;
  logic [7:0]  GPR_r2;
  logic        op_valid;
  logic        op_ready;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural registers, in-flight destinations, stall count
  logic [7:0] m_gpr [8];
  bit         m_busy [8];
  int         m_stall;

  logic [17:0] a_ir, b_ir, rnd_ir;
  logic [7:0]  exp_rs, exp_r2;

  always #5 clk = ~clk;

  gumnut_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_in     (ir_in),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .IR        (IR),
    .GPR_rs    (GPR_rs),
    .GPR_r2    (GPR_r2),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .stall_cnt (stall_cnt)
  );

  // 0 alu-imm, 1 shift, 2 load/inp, 3 store/out, 4 alu-reg, 5 control
  function automatic int m_kind(input logic [17:0] ir);
    if (ir[17] == 1'b0) return 0;
    if (ir[17:16] == 2'b10) return (ir[14] == 1'b1) ? 3 : 2;
    if (ir[17:15] == 3'b110) return 1;
    if (ir[17:14] == 4'b1110) return 4;
    return 5;
  endfunction

  function automatic logic [7:0] m_rs(input logic [17:0] ir);
    if (m_kind(ir) == 5) return 8'h00;
    return m_gpr[ir[10:8]];
  endfunction

  function automatic logic [7:0] m_r2(input logic [17:0] ir);
    if (m_kind(ir) == 4) return m_gpr[ir[7:5]];
    if (m_kind(ir) == 3) return m_gpr[ir[13:11]];
    return 8'h00;
  endfunction

  function automatic bit m_writes(input logic [17:0] ir);
    int k;
    k = m_kind(ir);
    return (k == 0 || k == 1 || k == 2 || k == 4) && (ir[13:11] != 3'd0);
  endfunction

  function automatic bit m_hazard(input logic [17:0] ir);
    int k;
    bit h;
    k = m_kind(ir);
    h = 1'b0;
    if (k != 5 && m_busy[ir[10:8]]) h = 1'b1;
    if (k == 4 && m_busy[ir[7:5]]) h = 1'b1;
    if (k == 3 && m_busy[ir[13:11]]) h = 1'b1;
    if (m_writes(ir) && m_busy[ir[13:11]]) h = 1'b1;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [2:0] idx, input logic [7:0] d);
    wb_en = 1'b1; wb_rd = idx; wb_data = d;
    tick();
    wb_en = 1'b0;
    if (idx != 3'd0) m_gpr[idx] = d;
    m_busy[idx] = 1'b0;
  endtask

  task automatic do_issue(input logic [17:0] ir, input string tag);
    logic [7:0] ers, er2;
    ir_in = ir; ir_valid = 1'b1;
    #1;
    chk({tag, ".ready"}, ir_ready, 1);
    ers = m_rs(ir);
    er2 = m_r2(ir);
    tick();
    ir_valid = 1'b0;
    chk({tag, ".op_valid"}, op_valid, 1);
    chk({tag, ".IR"}, IR, ir);
    chk({tag, ".GPR_rs"}, GPR_rs, ers);
    chk({tag, ".GPR_r2"}, GPR_r2, er2);
    if (m_writes(ir)) m_busy[ir[13:11]] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ir_in = 18'h0; ir_valid = 1'b0; op_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 3'd0; wb_data = 8'h00; m_stall = 0;
    for (int i = 0; i < 8; i++) begin m_gpr[i] = 8'h00; m_busy[i] = 1'b0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.op_valid", op_valid, 0);
    chk("rst.IR", IR, 0);
    chk("rst.GPR_rs", GPR_rs, 0);
    chk("rst.GPR_r2", GPR_r2, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    chk("rst.ir_ready", ir_ready, 1);
    rst_n = 1'b1;
    tick();

    // add r1,r1,r2 with r1=7, r2=3
    do_wb(3'd1, 8'd7);
    do_wb(3'd2, 8'd3);
    do_issue(18'b111_0001_001_010_00000, "add");
    chk("add.rs_const", GPR_rs, 8'd7);
    chk("add.r2_const", GPR_r2, 8'd3);
    do_wb(3'd1, 8'd7);

    // RAW hazard: add r3<=r1+r2 then sub reading r3
    do_issue({4'b1110, 3'd3, 3'd1, 3'd2, 5'd0}, "add_r3");
    b_ir = {4'b1110, 3'd4, 3'd3, 3'd1, 5'd1};
    ir_in = b_ir; ir_valid = 1'b1;
    #1;
    chk("haz.ready", ir_ready, 0);
    repeat (3) begin tick(); m_stall++; end
    chk("haz.stall_cnt", stall_cnt, m_stall);
    chk("haz.ready_hold", ir_ready, 0);
    wb_en = 1'b1; wb_rd = 3'd3; wb_data = 8'd10;
`ifdef GUMNUT_WB_BYPASS_EN
    #1;
    chk("haz.ready_wb", ir_ready, 1);
    tick();
    wb_en = 1'b0;
`else
    #1;
    chk("haz.ready_wb", ir_ready, 0);
    tick();
    m_stall++;
    wb_en = 1'b0;
    #1;
    chk("haz.ready_after", ir_ready, 1);
    tick();
`endif
    ir_valid = 1'b0;
    m_gpr[3] = 8'd10; m_busy[3] = 1'b0; m_busy[4] = 1'b1;
    chk("haz.op_valid", op_valid, 1);
    chk("haz.IR", IR, b_ir);
    chk("haz.GPR_rs", GPR_rs, 8'd10);
    chk("haz.GPR_r2", GPR_r2, 8'd7);
    chk("haz.stall_final", stall_cnt, m_stall);
    do_wb(3'd4, 8'h33);

    // Backpressure: outputs held while op_ready is low
    op_ready = 1'b0;
    a_ir = {1'b0, 3'b000, 3'd5, 3'd1, 8'h22};
    do_issue(a_ir, "bp_a");
    b_ir = {4'b1110, 3'd6, 3'd2, 3'd2, 5'd0};
    ir_in = b_ir; ir_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("bp.ready", ir_ready, 0);
      tick();
      chk("bp.IR_hold", IR, a_ir);
      chk("bp.rs_hold", GPR_rs, 8'd7);
      chk("bp.valid_hold", op_valid, 1);
    end
    op_ready = 1'b1;
    #1;
    chk("bp.ready_release", ir_ready, 1);
    exp_rs = m_rs(b_ir); exp_r2 = m_r2(b_ir);
    tick();
    ir_valid = 1'b0;
    m_busy[6] = 1'b1;
    chk("bp.IR_next", IR, b_ir);
    chk("bp.rs_next", GPR_rs, exp_rs);
    chk("bp.r2_next", GPR_r2, exp_r2);
    chk("bp.stall_cnt", stall_cnt, m_stall);
    tick();
    chk("bp.drain", op_valid, 0);
    do_wb(3'd5, 8'hA5);
    do_wb(3'd6, 8'h66);
    do_wb(3'd4, 8'h10);

    // Store reads rs and rd; leaves the scoreboard alone
    do_issue({2'b10, 2'b01, 3'd5, 3'd4, 8'h00}, "stm");
    chk("stm.rs_const", GPR_rs, 8'h10);
    chk("stm.r2_const", GPR_r2, 8'hA5);
    do_issue({1'b0, 3'b000, 3'd5, 3'd5, 8'h01}, "imm_r5");
    do_wb(3'd5, 8'hA5);

    // r0 ignores writes and reads zero; control class reads nothing
    do_wb(3'd0, 8'hFF);
    do_issue({4'b1110, 3'd1, 3'd0, 3'd0, 5'd0}, "r0");
    chk("r0.rs_const", GPR_rs, 8'h00);
    do_wb(3'd1, 8'd7);
    do_issue({5'b11110, 13'h1ABC}, "jump");
    chk("dir.stall_cnt", stall_cnt, m_stall);

    // Randomized instructions and writebacks
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) do_wb(3'($urandom_range(0, 7)), 8'($urandom));
      rnd_ir = 18'($urandom);
      if (m_hazard(rnd_ir)) begin
        ir_in = rnd_ir; ir_valid = 1'b1;
        #1;
        chk("rnd.stall_ready", ir_ready, 0);
        tick();
        m_stall++;
        ir_valid = 1'b0;
        chk("rnd.stall_cnt", stall_cnt, m_stall);
      end else begin
        do_issue(rnd_ir, "rnd");
      end
      for (int k = 1; k < 8; k++) begin
        if (m_busy[k] && ($urandom_range(0, 1) == 1)) do_wb(3'(k), 8'($urandom));
      end
    end
    for (int k = 1; k < 8; k++) begin
      if (m_busy[k]) do_wb(3'(k), 8'($urandom));
    end
    tick();
    chk("rnd.stall_final", stall_cnt, m_stall);

    // Reset while r3 pending and op_valid held
    op_ready = 1'b0;
    do_issue({4'b1110, 3'd3, 3'd1, 3'd2, 5'd0}, "pre_rst");
    b_ir = {4'b1110, 3'd4, 3'd3, 3'd1, 5'd0};
    ir_in = b_ir; ir_valid = 1'b1;
    tick(); m_stall++;
    tick(); m_stall++;
    chk("pre_rst.stall_cnt", stall_cnt, m_stall);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.op_valid", op_valid, 0);
    chk("rst2.IR", IR, 0);
    chk("rst2.GPR_rs", GPR_rs, 0);
    chk("rst2.stall_cnt", stall_cnt, 0);
    ir_valid = 1'b0; op_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin m_gpr[i] = 8'h00; m_busy[i] = 1'b0; end
    m_stall = 0;
    tick();
    do_issue(b_ir, "post_rst_r3");
    chk("post_rst.stall_cnt", stall_cnt, 0);
    do_wb(3'd4, 8'h01);
    do_wb(3'd1, 8'h5C);
    do_issue({1'b0, 3'b000, 3'd2, 3'd1, 8'h00}, "post_rst_wb");
    chk("post_rst.wb_rs", GPR_rs, 8'h5C);
    chk("post_rst.stall_end", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
